// File: rtl/perf_monitor_pkg.sv
// Shared definitions for the benchmark cycle counter and memory dump unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default widths and dump window.
package perf_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DATA_W             = 32;
  localparam int DEFAULT_CNT_W      = 32;
  localparam int DEFAULT_ADDR_W     = 7;
  localparam int DEFAULT_DUMP_BASE  = 0;
  localparam int DEFAULT_DUMP_WORDS = 16;

endpackage

// File: rtl/perf_monitor_if.sv
// Bundle between the perf monitor, the core debug read port and the dump consumer.
// Latency: n/a (wiring only).
// Backpressure: dump_valid/dump_ready stream; the word holds until accepted.
// master = monitor side; slave = core + consumer side.
interface perf_monitor_if #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 7
);
  logic              count_start;  // core start marker level
  logic              count_stop;   // core stop marker level
  logic [31:0]       data;         // debug read data, combinational from address
  logic [ADDR_W-1:0] address;      // debug read address
  logic [CNT_W-1:0]  cycles;       // measured cycle count
  logic              overflow;     // counter saturated during the run
  logic              busy;         // RUN, FETCH or SEND
  logic              done;         // dump finished, results stable
  logic              dump_valid;
  logic [31:0]       dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_ready;

  modport master (
    input  count_start, count_stop, data, dump_ready,
    output address, cycles, overflow, busy, done, dump_valid, dump_data, dump_addr
  );

  modport slave (
    output count_start, count_stop, data, dump_ready,
    input  address, cycles, overflow, busy, done, dump_valid, dump_data, dump_addr
  );
endinterface

// File: rtl/perf_monitor_edge_rise.sv
// Rising-edge detector for a level strobe; a held level yields one pulse.
// Latency: pulse is combinational in the cycle the level first reads high.
// Backpressure: none.
// Ports: clk, reset (async, active-high), level in, pulse out.
module perf_monitor_edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/perf_monitor.sv
// Counts cycles between core start/stop strobes, then dumps a data-memory window.
// Latency: count = edge distance - 1; dump costs 2 cycles per word (FETCH + SEND).
// Backpressure: SEND holds dump_data/dump_addr/dump_valid until dump_ready.
// Ports: clk, reset (async, active-high), bus (perf_monitor_if.master).
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DUMP_BASE  = DEFAULT_DUMP_BASE,
  parameter int DUMP_WORDS = DEFAULT_DUMP_WORDS
) (
  input  logic            clk,
  input  logic            reset,
  perf_monitor_if.master  bus
);

  // A one-word dump still needs a 1-bit index register.
  localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DUMP_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DUMP_BASE);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             start_pulse;
  logic             stop_pulse;

  perf_monitor_edge_rise u_start_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.count_start),
    .pulse (start_pulse)
  );

  perf_monitor_edge_rise u_stop_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.count_stop),
    .pulse (stop_pulse)
  );

  // The debug address is a register that advances alongside idx, so it is
  // already valid for the whole FETCH cycle where iData is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      bus.address    <= '0;
      bus.cycles     <= '0;
      bus.overflow   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.dump_valid <= 1'b0;
      bus.dump_data  <= '0;
      bus.dump_addr  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // A stop edge coinciding with the start edge is simply dropped.
          if (start_pulse) begin
            state        <= ST_RUN;
            bus.cycles   <= '0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          // The stop cycle itself is not counted.
          if (stop_pulse) begin
            state       <= ST_FETCH;
            idx         <= '0;
            bus.address <= BASE_ADDR;
          end else if (&bus.cycles) begin
            bus.overflow <= 1'b1;
          end else begin
            bus.cycles <= bus.cycles + CNT_W'(1);
          end
        end
        ST_FETCH: begin
          bus.dump_data  <= bus.data;
          bus.dump_addr  <= bus.address;
          bus.dump_valid <= 1'b1;
          state          <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.dump_ready) begin
            bus.dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state       <= ST_DONE;
              bus.address <= '0;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
            end else begin
              state       <= ST_FETCH;
              idx         <= idx + IDX_W'(1);
              bus.address <= bus.address + ADDR_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (start_pulse) begin
            state        <= ST_RUN;
            bus.cycles   <= '0;
            bus.overflow <= 1'b0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
